bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
//  Shares the single burst-memory port between the instruction cache and the data cache.
//  Each cache issues 256-bit line requests. Dcache requests may be reads or write-backs; icache requests are reads only.
//  The arbiter grants one requester at a time and serializes its line into 64-bit bursts on the bmem port.
//  For reads it gathers the returned beats back into a full line.
//  It sits between the caches and burst_memory inside mp4, and exports a conflict counter for the perf report.
// PARAMETERS
//  ADDR_W     32   address width (bytes)
//  BEAT_W     64   bmem data width per beat
//  BURST_LEN  4    beats per line; line = BEAT_W*BURST_LEN = 256 bits
//  CNT_W      32   width of perf_conflict_count (saturating)
// PORTS
//  clk                  in   1       clock, rising edge
//  rst                  in   1       asynchronous reset, active-high
//  i_addr               in   32      icache line address
//  i_read               in   1       icache line read request, level, held until i_resp
//  i_rdata              out  256     line returned to icache, valid while i_resp=1
//  i_resp               out  1       one-cycle completion pulse to icache
//  d_addr               in   32      dcache line address
//  d_read               in   1       dcache line read request, level
//  d_write              in   1       dcache line write-back request, level
//  d_wdata              in   256     line to write, held stable with d_write
//  d_rdata              out  256     line returned to dcache, valid while d_resp=1
//  d_resp               out  1       one-cycle completion pulse to dcache
//  bmem_address         out  32      line-aligned burst address {addr[31:5],5'b0}
//  bmem_read            out  1       burst read, held for whole burst
//  bmem_write           out  1       burst write, held for whole burst
//  bmem_rdata           in   64      read beat, valid when bmem_resp=1
//  bmem_wdata           out  64      write beat k = line[64k+63:64k]
//  bmem_resp            in   1       beat handshake: one beat transferred per cycle it is high
//  perf_conflict_count  out  CNT_W   cycles a request waited while the other requester owned the port
// BEHAVIOUR
//  Reset
//   - State goes to IDLE, beat=0, last_grant=D.
//   - All outputs are 0, including rdata/resp and the counter.
//   - A reset mid-burst abandons the burst; bmem_read and bmem_write drop immediately.
//  States: IDLE, I_RD, D_RD, D_WR, DONE
//  IDLE
//   - Arbitration is registered.
//   - Only one requester active: grant it.
//   - Both active: round-robin. Grant the requester not equal to last_grant; last_grant <= granted.
//   - Dcache: if d_write and d_read are both high, treat it as a write (illegal input; write wins).
//   - On grant, latch address and write line into internal registers, beat <= 0, then enter I_RD, D_RD or D_WR.
//   - First bmem_read/bmem_write is asserted in the cycle after the request is first seen (1-cycle arbitration latency).
//  I_RD / D_RD
//   - bmem_read=1 and bmem_address = latched address.
//   - On each cycle with bmem_resp=1: buf[beat] <= bmem_rdata, beat <= beat+1.
//   - On the beat with beat==BURST_LEN-1, go to DONE.
//   - bmem_resp=0 cycles are wait states; beat holds.
//  D_WR
//   - bmem_write=1; bmem_wdata = latched line beat[beat]; advance on bmem_resp as above.
//   - bmem_wdata changes only after a handshake.
//  DONE (one cycle)
//   - bmem_read and bmem_write are 0.
//   - The granted requester sees resp=1, and its rdata = assembled buffer (reads; 0 for writes).
//   - Next state is IDLE.
//   - The requester drops its request on the edge ending DONE, so IDLE never re-grants a finished request.
//   - Back-to-back minimum per line: 1 (IDLE) + BURST_LEN + 1 (DONE) cycles.
//  Output rules
//   - i_resp and d_resp are never both high.
//   - resp and rdata are registered outputs.
//   - rdata returns to 0 when resp is low.
//  perf_conflict_count
//   - +1 each cycle in I_RD or D_RD/D_WR while the non-granted requester has a request high.
//   - Saturates at all-ones; no wrap.
//   - Reset is its only clear.
//  Beat counter is clog2(BURST_LEN) bits; it is reset to 0 on every grant, and no wrap occurs within a burst.
// TESTING
//  1. Icache only: i_read, addr 0x6000_0044; memory returns 4 beats A0..A3 with no gaps.
//     -> bmem_address=0x6000_0040; i_resp is 1 cycle later with line {A3,A2,A1,A0}; total 6 cycles.
//  2. Dcache write-back: d_write, line L; memory stalls 2 cycles between beats.
//     -> bmem_wdata steps L[63:0] through L[255:192] exactly on resp beats; d_resp=1 once; d_rdata=0.
//  3. Simultaneous i_read and d_read from reset (last_grant=D).
//     -> icache served first; d_read then served next.
//     -> perf_conflict_count=4 with zero-wait memory.
//  4. Continuous contention: both requests re-issue immediately after each resp.
//     -> grants alternate I,D,I,D; no requester is served twice in a row.
//  5. Reset asserted during beat 2 of a D_RD burst.
//     -> bmem_read=0 without waiting for a clock edge; all resp=0; counter=0.
//     -> after release, a fresh i_read completes normally.
//  6. d_read and d_write both high -> a write burst is issued; bmem_read stays 0 throughout.

Source files
------------

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: round-robin arbiter sharing one burst-memory port between icache and dcache,
// serializing 256-bit lines into BURST_LEN beats and reassembling read lines.
module bmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic                        i_read,
  output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
  output logic                        i_resp,
  input  logic [ADDR_W-1:0]           d_addr,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
  output logic                        d_resp,
  output logic [ADDR_W-1:0]           bmem_address,
  output logic                        bmem_read,
  output logic                        bmem_write,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_resp,
  output logic [CNT_W-1:0]            perf_conflict_count
);
  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int BW     = $clog2(BURST_LEN);
  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;
  state_t state, next;
  logic [BW-1:0]         beat;
  logic                  last_d;
  logic [ADDR_W-OFF-1:0] addr_q;
  logic [LINE_W-1:0]     wline, rbuf, line_full;
  logic                  d_req, pick_d, busy, last_beat, unused_bits;
  assign unused_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};
  assign d_req     = d_read | d_write;
  assign pick_d    = d_req & (~i_read | ~last_d);
  assign busy      = bmem_read | bmem_write;
  assign last_beat = bmem_resp && beat == BW'(BURST_LEN - 1);
  assign bmem_address = {addr_q, OFF'(0)};
  assign bmem_wdata   = bmem_write ? wline[beat*BEAT_W +: BEAT_W] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next       = state;
    bmem_read  = state == I_RD || state == D_RD;
    bmem_write = state == D_WR;
    case (state)
      IDLE:             next = pick_d ? (d_write ? D_WR : D_RD) : (i_read ? I_RD : IDLE);
      I_RD, D_RD, D_WR: next = last_beat ? DONE : state;
      default:          next = IDLE;
    endcase
  end
  // The beat being handshaked this cycle goes straight into the returned line.
  always_comb begin
    line_full = rbuf;
    line_full[beat*BEAT_W +: BEAT_W] = bmem_rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat    <= '0;
      last_d  <= 1'b1;
      addr_q  <= '0;
      wline   <= '0;
      rbuf    <= '0;
      i_resp  <= 1'b0;
      d_resp  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      perf_conflict_count <= '0;
    end else begin
      if (state == IDLE && (i_read || d_req)) begin
        last_d <= pick_d;
        addr_q <= pick_d ? d_addr[ADDR_W-1:OFF] : i_addr[ADDR_W-1:OFF];
        wline  <= d_wdata;
        beat   <= '0;
      end
      if (busy && bmem_resp) beat <= beat + 1'b1;
      if (bmem_read && bmem_resp) rbuf[beat*BEAT_W +: BEAT_W] <= bmem_rdata;
      i_resp  <= state == I_RD && last_beat;
      d_resp  <= (state == D_RD || state == D_WR) && last_beat;
      i_rdata <= state == I_RD && last_beat ? line_full : '0;
      d_rdata <= state == D_RD && last_beat ? line_full : '0;
      if (busy && (state == I_RD ? d_req : i_read) && ~&perf_conflict_count)
        perf_conflict_count <= perf_conflict_count + 1'b1;
    end
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: randomized sessions against a round-robin reference model, with a
// behavioural burst memory and a scoreboard monitor that checks every completion.
module tb_bmem_arbiter;
  localparam int CW = 8;
  logic clk = 0, rst;
  logic [31:0] i_addr, d_addr, bmem_address;
  logic i_read, i_resp, d_read, d_write, d_resp, bmem_read, bmem_write, bmem_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic [63:0] bmem_rdata, bmem_wdata;
  logic [CW-1:0] perf_conflict_count;
  always #5 clk = ~clk;
  bmem_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_resp(d_resp), .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp),
    .perf_conflict_count(perf_conflict_count));
  typedef struct {logic [31:0] addr; bit rd; bit wr; logic [255:0] wdata; int g;} txn_t;
  typedef struct {bit is_d; bit wr; logic [31:0] al; logic [255:0] line;} exp_t;
  exp_t sb[$];
  int waitq[$];
  txn_t itx[$], dtx[$];
  logic [255:0] ref_mem[logic [31:0]];
  logic [255:0] slave_mem[logic [31:0]];
  int checks = 0, errors = 0, exp_conf = 0, lat_i, lat_d;
  bit last_d = 1;
  function automatic logic [255:0] init_line(logic [31:0] a);
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[32*j +: 32] = (a * (j + 3)) ^ (32'h9E37_79B9 + j);
    return l;
  endfunction
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  // Burst memory: g wait cycles before every beat of a burst, g taken from waitq per burst.
  int sk = 0, sgap = 0, sg = 0;
  bit sact = 0, s_wr = 0, s_bad = 0;
  logic [31:0] s_addr = 0;
  initial begin
    logic [255:0] ln;
    bmem_resp = 0;
    bmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst || !(bmem_read || bmem_write)) begin
        sact = 0; bmem_resp = 0; sk = 0;
      end else begin
        if (!sact) begin
          sact = 1; sk = 0; s_addr = bmem_address; s_wr = bmem_write; s_bad = 0;
          sg = waitq.size() > 0 ? waitq.pop_front() : 0;
          sgap = sg;
          if (!slave_mem.exists(s_addr)) slave_mem[s_addr] = init_line(s_addr);
        end
        if ((bmem_read && bmem_write) || bmem_write != s_wr || bmem_address != s_addr) s_bad = 1;
        if (sgap > 0 || sk >= 4) begin
          bmem_resp = 0;
          if (sgap > 0) sgap--;
        end else begin
          bmem_resp = 1;
          ln = slave_mem[s_addr];
          if (s_wr) ln[64*sk +: 64] = bmem_wdata;
          else bmem_rdata = ln[64*sk +: 64];
          slave_mem[s_addr] = ln;
          sk++;
          sgap = sg;
        end
      end
    end
  end
  // Monitor: pops the expected completion whenever either cache sees resp.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("resp_exclusive", 256'(i_resp & d_resp), 256'(0));
      chk("rdata_idle_zero", (i_resp ? '0 : i_rdata) | (d_resp ? '0 : d_rdata), 256'(0));
      if (i_resp || d_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got i=%0b d=%0b want none", i_resp, d_resp);
        end else begin
          e = sb.pop_front();
          chk("grant_order_is_d", 256'(d_resp), 256'(e.is_d));
          chk("rdata", e.is_d ? d_rdata : i_rdata, e.wr ? 256'(0) : e.line);
          chk("burst_addr_kind_ok", {s_addr, s_wr, s_bad}, {e.al, e.wr, 1'b0});
          if (e.wr) chk("written_line", slave_mem[e.al], e.line);
        end
      end
    end
  end
  task automatic wait_resp(input bit is_d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_resp : i_resp) && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL resp_timeout got none want resp is_d=%0b", is_d);
    end
  endtask
  task automatic drive_i();
    foreach (itx[k]) begin
      i_addr = itx[k].addr; i_read = 1;
      wait_resp(0, lat_i);
      @(posedge clk); #1;
    end
    i_read = 0;
  endtask
  task automatic drive_d();
    foreach (dtx[k]) begin
      d_addr = dtx[k].addr; d_read = dtx[k].rd; d_write = dtx[k].wr; d_wdata = dtx[k].wdata;
      wait_resp(1, lat_d);
      @(posedge clk); #1;
    end
    d_read = 0; d_write = 0;
  endtask
  function automatic txn_t mk(bit is_d, int g);
    txn_t t;
    int r = $urandom_range(0, 3);
    t.addr = 32'h6000_0000 + ($urandom_range(0, 5) << 5) + $urandom_range(0, 31);
    t.rd = !is_d || r != 2;
    t.wr = is_d && r >= 2;
    for (int j = 0; j < 8; j++) t.wdata[32*j +: 32] = $urandom;
    t.g = g;
    return t;
  endfunction
  // Reference: both requesters hold their request until their list is done, so each grant
  // alternates while both have work; a burst adds its full length to the counter if the other waits.
  task automatic run_session();
    int pi = 0, pd = 0, dur;
    bit gd, oth;
    txn_t t;
    exp_t e;
    while (pi < itx.size() || pd < dtx.size()) begin
      gd  = (pi < itx.size() && pd < dtx.size()) ? !last_d : pd < dtx.size();
      oth = gd ? pi < itx.size() : pd < dtx.size();
      if (gd) t = dtx[pd]; else t = itx[pi];
      e.is_d = gd;
      e.wr = gd && t.wr;
      e.al = {t.addr[31:5], 5'b0};
      e.line = e.wr ? t.wdata : (ref_mem.exists(e.al) ? ref_mem[e.al] : init_line(e.al));
      if (e.wr) ref_mem[e.al] = t.wdata;
      sb.push_back(e);
      waitq.push_back(t.g);
      dur = 4 * (t.g + 1);
      if (oth) exp_conf = exp_conf + dur > 255 ? 255 : exp_conf + dur;
      last_d = gd;
      if (gd) pd++; else pi++;
    end
    fork
      drive_i();
      drive_d();
    join
    chk("conflict_count", 256'(perf_conflict_count), 256'(exp_conf));
    itx.delete();
    dtx.delete();
  endtask
  initial begin
    txn_t t;
    int n, ki, kd;
    i_addr = 0; i_read = 0; d_addr = 0; d_read = 0; d_write = 0; d_wdata = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {bmem_read, bmem_write, i_resp, d_resp}, 256'(0));
    chk("reset_addr_wdata", {bmem_address, bmem_wdata}, 256'(0));
    chk("reset_rdata", i_rdata | d_rdata, 256'(0));
    chk("reset_count", 256'(perf_conflict_count), 256'(0));
    rst = 0;
    @(posedge clk); #1;
    // simultaneous reads from reset: icache first, 4 conflict cycles
    t = mk(0, 0); itx.push_back(t);
    t = mk(1, 0); t.rd = 1; t.wr = 0; dtx.push_back(t);
    run_session();
    chk("t3_conflict_is_4", 256'(perf_conflict_count), 256'(4));
    // lone icache read, zero-wait memory: 6 cycles request to resp
    t = mk(0, 0); t.addr = 32'h6000_0044; itx.push_back(t);
    run_session();
    chk("t1_latency", 256'(lat_i), 256'(6));
    // write-back with 2 stall cycles before each beat
    t = mk(1, 2); t.rd = 0; t.wr = 1; dtx.push_back(t);
    run_session();
    // read and write both high: write wins
    t = mk(1, 0); t.rd = 1; t.wr = 1; dtx.push_back(t);
    run_session();
    // continuous contention
    repeat (3) begin
      itx.push_back(mk(0, $urandom_range(0, 1)));
      dtx.push_back(mk(1, $urandom_range(0, 1)));
    end
    run_session();
    repeat (25) begin
      ki = $urandom_range(0, 3);
      kd = $urandom_range(ki == 0 ? 1 : 0, 3);
      repeat (ki) itx.push_back(mk(0, $urandom_range(0, 2)));
      repeat (kd) dtx.push_back(mk(1, $urandom_range(0, 2)));
      run_session();
    end
    // reset during beat 2 of a dcache read
    t = mk(1, 0);
    d_addr = t.addr; d_read = 1; d_write = 0;
    waitq.push_back(0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (sk != 3 && n < 100);
    chk("t5_reached_beat2", 256'(sk), 256'(3));
    #2 rst = 1;
    #1;
    chk("t5_bmem_drop", {bmem_read, bmem_write}, 256'(0));
    chk("t5_resp", {i_resp, d_resp}, 256'(0));
    chk("t5_count", 256'(perf_conflict_count), 256'(0));
    d_read = 0;
    @(posedge clk); #1;
    rst = 0;
    last_d = 1; exp_conf = 0;
    waitq.delete();
    @(posedge clk); #1;
    itx.push_back(mk(0, 1));
    run_session();
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
